// File: rtl/out_display_driver.sv
// Captures a signed value on a flagOUT strobe and converts its magnitude to BCD by double-dabble.
// Drives three active-low 7-segment digits plus a sign digit, with leading-zero blanking and overflow dashes.
module out_display_driver #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_BITS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flagOUT,
  input  logic [WIDTH-1:0] Value,
  output logic             busy,
  output logic             done,
  output logic [6:0]       OUT_H,
  output logic [6:0]       OUT_T,
  output logic [6:0]       OUT_O,
  output logic [6:0]       OUT_N,
  output logic [1:0]       fsm_state
);

  // Handshake: flagOUT is a load strobe, accepted only when fsm_state is IDLE;
  // busy is high while converting, and done pulses for one cycle in the cycle
  // right after the edge that updated OUT_H/T/O/N.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int CW = $clog2(SHIFT_BITS + 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  state_t                state;
  logic [11:0]           bcd;
  logic [SHIFT_BITS-1:0] bin;
  logic [CW-1:0]         count;
  logic                  neg;
  logic                  ovf;

  logic                  sign;
  logic [WIDTH-1:0]      mag;
  logic                  too_big;
  logic [11:0]           bcd_adj;
  logic [11:0]           bcd_next;
  logic [SHIFT_BITS-1:0] bin_next;
  logic [3:0]            hd, td, od;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] d);
    dabble = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_comb begin
    sign     = Value[WIDTH-1];
    mag      = sign ? (WIDTH'(0) - Value) : Value;
    too_big  = mag > WIDTH'(999);
    bcd_adj  = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};
    bcd_next = {bcd_adj[10:0], bin[SHIFT_BITS-1]};
    bin_next = {bin[SHIFT_BITS-2:0], 1'b0};
    // Final digits come from the shift result of the last iteration, not the stored one.
    hd       = bcd_next[11:8];
    td       = bcd_next[7:4];
    od       = bcd_next[3:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      OUT_H <= BLANK;
      OUT_T <= BLANK;
      OUT_O <= BLANK;
      OUT_N <= BLANK;
      bcd   <= '0;
      bin   <= '0;
      count <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (flagOUT) begin
            neg <= sign && (mag != '0);
            if (too_big) begin
              ovf   <= 1'b1;
              state <= DONE;
            end else begin
              bin   <= mag[SHIFT_BITS-1:0];
              bcd   <= '0;
              count <= '0;
              busy  <= 1'b1;
              state <= CONVERT;
            end
          end
        end
        CONVERT: begin
          bcd   <= bcd_next;
          bin   <= bin_next;
          count <= count + 1'b1;
          if (count == CW'(SHIFT_BITS - 1)) begin
            OUT_H <= (hd == 4'd0) ? BLANK : seg7(hd);
            OUT_T <= (hd == 4'd0 && td == 4'd0) ? BLANK : seg7(td);
            OUT_O <= seg7(od);
            OUT_N <= neg ? DASH : BLANK;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // Overflow enters DONE without a display update; it is registered here, one edge later.
          if (ovf) begin
            OUT_H <= DASH;
            OUT_T <= DASH;
            OUT_O <= DASH;
            OUT_N <= neg ? DASH : BLANK;
            done  <= 1'b1;
            ovf   <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_out_display_driver.sv
// Bench for out_display_driver: drives strobes, queues expected displays from a decimal model,
// and compares them whenever done pulses.
module tb_out_display_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        flagOUT;
  logic [31:0] Value;
  logic        busy;
  logic        done;
  logic [6:0]  OUT_H, OUT_T, OUT_O, OUT_N;
  logic [1:0]  fsm_state;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [27:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_count = 0;

  out_display_driver #(.WIDTH(32), .SHIFT_BITS(10)) dut (
    .clock(clock), .reset(reset), .flagOUT(flagOUT), .Value(Value),
    .busy(busy), .done(done), .OUT_H(OUT_H), .OUT_T(OUT_T), .OUT_O(OUT_O),
    .OUT_N(OUT_N), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned mag_of(input logic [31:0] v);
    mag_of = v[31] ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
  endfunction

  function automatic logic [27:0] exp_disp(input logic [31:0] v);
    longint unsigned m;
    int h, t, o;
    logic [6:0] eh, et, eo, en;
    m = mag_of(v);
    en = (v[31] && m != 0) ? DASH : BLANK;
    if (m > 999) begin
      eh = DASH; et = DASH; eo = DASH;
    end else begin
      h = int'(m / 100);
      t = int'((m / 10) % 10);
      o = int'(m % 10);
      eh = (h == 0) ? BLANK : seg_tab[h];
      et = (h == 0 && t == 0) ? BLANK : seg_tab[t];
      eo = seg_tab[o];
    end
    exp_disp = {eh, et, eo, en};
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      done_count++;
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("display", {4'd0, OUT_H, OUT_T, OUT_O, OUT_N}, {4'd0, exp_q.pop_front()});
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    check("rst_h", {25'd0, OUT_H}, {25'd0, BLANK});
    check("rst_t", {25'd0, OUT_T}, {25'd0, BLANK});
    check("rst_o", {25'd0, OUT_O}, {25'd0, BLANK});
    check("rst_n", {25'd0, OUT_N}, {25'd0, BLANK});
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_convert(input logic [31:0] v);
    int  lat, busy_n;
    bit  seen, ovf;
    ovf = mag_of(v) > 999;
    @(negedge clock);
    Value   = v;
    flagOUT = 1'b1;
    exp_q.push_back(exp_disp(v));
    @(posedge clock);
    #1;
    flagOUT = 1'b0;
    Value   = $urandom;
    busy_n  = busy ? 1 : 0;
    lat     = 0;
    seen    = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(posedge clock);
      #1;
      if (done) begin
        seen = 1;
        lat  = c;
      end else if (busy) busy_n++;
    end
    check("latency", lat, ovf ? 32'd1 : 32'd10);
    check("busy_cycles", busy_n, ovf ? 32'd0 : 32'd10);
    @(posedge clock);
    #1;
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dc0;
    logic [31:0] v;
    reset   = 1'b1;
    flagOUT = 1'b0;
    Value   = '0;
    do_reset(2);

    run_convert(32'd123);
    run_convert(32'hFFFFFFD3);
    run_convert(32'd1000);
    run_convert(32'h80000000);
    run_convert(32'd0);
    run_convert(32'd999);
    run_convert(32'hFFFFFC19);
    run_convert(32'hFFFFFC18);

    for (int i = 0; i < 8; i++) begin
      v = 32'($urandom_range(0, 999));
      if (i == 7) v = 32'($urandom_range(1000, 100000));
      if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      run_convert(v);
    end

    // A second strobe during conversion must be ignored.
    dc0 = done_count;
    @(negedge clock);
    Value   = 32'd500;
    flagOUT = 1'b1;
    exp_q.push_back(exp_disp(32'd500));
    @(posedge clock);
    #1;
    flagOUT = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    Value   = 32'd7;
    flagOUT = 1'b1;
    @(posedge clock);
    #1;
    flagOUT = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    check("restrobe_done_count", done_count - dc0, 32'd1);

    // Reset mid-conversion aborts with no done pulse.
    dc0 = done_count;
    @(negedge clock);
    Value   = 32'd42;
    flagOUT = 1'b1;
    @(posedge clock);
    #1;
    flagOUT = 1'b0;
    repeat (4) @(posedge clock);
    do_reset(1);
    repeat (15) @(posedge clock);
    #1;
    check("abort_no_done", done_count - dc0, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);

    run_convert(32'd88);
    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
